vec_pipe_stage_ctrl: RTL and testbench

Handshaked, flushable pipeline stage for vector operands between two stages of the vector CPU datapath.
It holds a DEPTH-element vector in a main register plus a one-entry skid register, so upstream sees a registered ready and no combinational path from out_ready.
The hazard unit flushes it on branch mispredict or exception.
It also counts downstream stall cycles for performance monitoring.

---
 rtl/vec_pkg.sv | 20 ++
 rtl/flopenrvec.sv | 30 +++
 rtl/vec_pipe_stage_ctrl.sv | 126 ++++++++++++
 tb/tb_vec_pipe_stage_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// +------------------------------------------------------------------+
// | vec_pkg : shared types for the vector pipeline stage             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package vec_pkg;
  localparam int VEC_WIDTH = 32;
  localparam int VEC_DEPTH = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_t;

  typedef logic [VEC_WIDTH-1:0] vec_t [0:VEC_DEPTH-1];
endpackage

`default_nettype wire

// File: rtl/flopenrvec.sv
// +------------------------------------------------------------------+
// | flopenrvec : enabled vector register, synchronous active-low rst |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module flopenrvec
  import vec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i [0:DEPTH-1],
  output logic [WIDTH-1:0] q_o [0:DEPTH-1]
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) q_o[i] <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vec_pipe_stage_ctrl.sv
// +------------------------------------------------------------------+
// | vec_pipe_stage_ctrl : flushable skid-buffered vector pipe stage  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module vec_pipe_stage_ctrl
  import vec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data [0:DEPTH-1],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data [0:DEPTH-1],
  output logic [1:0]       occupancy,
  output logic [CNTW-1:0]  stall_cnt
);

  typedef logic [WIDTH-1:0] vec_lt [0:DEPTH-1];

  stage_state_t    state_q, state_d;
  vec_lt           main_q, main_d, skid_q;
  logic            main_en, skid_en, main_from_skid;
  logic            accept, emit;
  logic [CNTW-1:0] stall_q, stall_d;

  // Handshake outputs decode from state only, so in_ready never sees out_ready.
  assign in_ready  = (state_q != SKID);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = (state_q == EMPTY) ? 2'd0 : (state_q == FULL) ? 2'd1 : 2'd2;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
          main_en = 1'b1;
        end
      end
      FULL: begin
        if (accept && emit) begin
          main_en = 1'b1;
        end else if (accept) begin
          state_d = SKID;
          skid_en = 1'b1;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        if (emit) begin
          state_d        = FULL;
          main_en        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush keeps the data registers untouched; the vectors just become invalid.
    if (flush) begin
      state_d = EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      main_d[i] = main_from_skid ? skid_q[i] : in_data[i];
    end
  end

  flopenrvec #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .en_i  (main_en),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  flopenrvec #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en_i  (skid_en),
    .d_i   (in_data),
    .q_o   (skid_q)
  );

  assign out_data = main_q;

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNTW{1'b1}})) begin
      stall_d = stall_q + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_vec_pipe_stage_ctrl.sv
// +------------------------------------------------------------------+
// | tb_vec_pipe_stage_ctrl : table, directed and random checks       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_vec_pipe_stage_ctrl;

  typedef logic [31:0] tvec_t [0:3];

  typedef struct {
    logic       rn;
    logic       fl;
    logic       iv;
    int         din_id;
    logic       ordy;
    logic       ov;
    logic       ir;
    logic [1:0] occ;
    int         dout_id;
    int         stall;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  tvec_t       in_data;
  logic        in_ready, out_valid, in_ready_s, out_valid_s;
  tvec_t       out_data, out_data_s;
  logic [1:0]  occupancy, occupancy_s;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt_s;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: a FIFO of at most two vectors plus an unbounded stall tally.
  tvec_t mq[$];
  tvec_t m_main;
  int    m_stall;

  rec_t tbl[$];

  always #5 clk = ~clk;

  vec_pipe_stage_ctrl #(.WIDTH(32), .DEPTH(4), .CNTW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  vec_pipe_stage_ctrl #(.WIDTH(32), .DEPTH(4), .CNTW(4)) dut_s (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .in_data   (in_data),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .out_data  (out_data_s),
    .occupancy (occupancy_s),
    .stall_cnt (stall_cnt_s)
  );

  function automatic tvec_t vec_of(input int id);
    tvec_t v;
    for (int i = 0; i < 4; i++) begin
      case (id)
        0:       v[i] = 32'd0;
        1:       v[i] = 32'(i + 1);
        default: v[i] = 32'((id - 2) * 4 + i);
      endcase
    end
    return v;
  endfunction

  function automatic rec_t mk(input logic rn, fl, iv, input int din_id, input logic ordy,
                              input logic ov, ir, input logic [1:0] occ,
                              input int dout_id, input int stall);
    rec_t r;
    r.rn = rn; r.fl = fl; r.iv = iv; r.din_id = din_id; r.ordy = ordy;
    r.ov = ov; r.ir = ir; r.occ = occ; r.dout_id = dout_id; r.stall = stall;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic rn, fl, iv, input tvec_t din, input logic ordy);
    bit ov, ir;
    if (!rn) begin
      mq.delete();
      m_main  = vec_of(0);
      m_stall = 0;
    end else begin
      ov = (mq.size() != 0);
      ir = (mq.size() < 2);
      if (ov && !ordy) m_stall++;
      if (fl) begin
        mq.delete();
      end else begin
        if (ov && ordy) void'(mq.pop_front());
        if (iv && ir) mq.push_back(din);
      end
      if (mq.size() != 0) m_main = mq[0];
    end
  endtask

  task automatic step(input logic rn, fl, iv, input tvec_t din, input logic ordy);
    reset = rn; flush = fl; in_valid = iv; in_data = din; out_ready = ordy;
    @(posedge clk);
    model_update(rn, fl, iv, din, ordy);
    #1;
  endtask

  task automatic check_model(input string tag);
    int exp16, exp4;
    exp16 = (m_stall > 65535) ? 65535 : m_stall;
    exp4  = (m_stall > 15) ? 15 : m_stall;
    chk({tag, " out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
    chk({tag, " in_ready"},  64'(in_ready),  64'(mq.size() < 2));
    chk({tag, " occupancy"}, 64'(occupancy), 64'(mq.size()));
    for (int i = 0; i < 4; i++) chk({tag, " out_data"}, 64'(out_data[i]), 64'(m_main[i]));
    chk({tag, " stall16"}, 64'(stall_cnt),   64'(exp16));
    chk({tag, " stall4"},  64'(stall_cnt_s), 64'(exp4));
    chk({tag, " occ_s"},   64'(occupancy_s), 64'(mq.size()));
  endtask

  initial begin
    // ids: 0=zero 1={1,2,3,4} 2=A 3=B 4=C 5=D
    tbl.push_back(mk(0,0,1,1,0, 0,1,0,0,0));
    tbl.push_back(mk(0,0,1,1,0, 0,1,0,0,0));
    tbl.push_back(mk(1,0,0,0,1, 0,1,0,0,0));
    tbl.push_back(mk(1,0,1,2,1, 1,1,1,2,0));
    tbl.push_back(mk(1,0,1,3,1, 1,1,1,3,0));
    tbl.push_back(mk(1,0,0,0,1, 0,1,0,3,0));
    tbl.push_back(mk(1,0,1,2,0, 1,1,1,2,0));
    tbl.push_back(mk(1,0,1,3,0, 1,0,2,2,1));
    tbl.push_back(mk(1,0,1,4,0, 1,0,2,2,2));
    tbl.push_back(mk(1,0,1,4,0, 1,0,2,2,3));
    tbl.push_back(mk(1,0,1,4,1, 1,1,1,3,3));
    tbl.push_back(mk(1,0,1,4,1, 1,1,1,4,3));
    tbl.push_back(mk(1,0,0,0,1, 0,1,0,4,3));
    tbl.push_back(mk(1,0,1,2,0, 1,1,1,2,3));
    tbl.push_back(mk(1,0,1,3,0, 1,0,2,2,4));
    tbl.push_back(mk(1,1,1,4,0, 0,1,0,2,5));
    tbl.push_back(mk(1,0,1,5,1, 1,1,1,5,5));
    tbl.push_back(mk(1,0,0,0,1, 0,1,0,5,5));
    tbl.push_back(mk(1,0,1,2,0, 1,1,1,2,5));
    tbl.push_back(mk(1,0,1,3,0, 1,0,2,2,6));
    tbl.push_back(mk(0,0,1,4,0, 0,1,0,0,0));
    tbl.push_back(mk(1,0,1,2,1, 1,1,1,2,0));
    tbl.push_back(mk(1,0,0,0,1, 0,1,0,2,0));

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = vec_of(0);
    m_main = vec_of(0);
    m_stall = 0;
    @(negedge clk);

    for (int k = 0; k < tbl.size(); k++) begin
      tvec_t exp_d;
      step(tbl[k].rn, tbl[k].fl, tbl[k].iv, vec_of(tbl[k].din_id), tbl[k].ordy);
      exp_d = vec_of(tbl[k].dout_id);
      chk($sformatf("tbl%0d out_valid", k), 64'(out_valid), 64'(tbl[k].ov));
      chk($sformatf("tbl%0d in_ready", k),  64'(in_ready),  64'(tbl[k].ir));
      chk($sformatf("tbl%0d occupancy", k), 64'(occupancy), 64'(tbl[k].occ));
      for (int i = 0; i < 4; i++)
        chk($sformatf("tbl%0d out_data[%0d]", k, i), 64'(out_data[i]), 64'(exp_d[i]));
      chk($sformatf("tbl%0d stall16", k), 64'(stall_cnt),   64'(tbl[k].stall));
      chk($sformatf("tbl%0d stall4", k),  64'(stall_cnt_s), 64'(tbl[k].stall));
    end

    // Flush in FULL with a concurrent emit and offered vector.
    step(1, 0, 1, vec_of(2), 0);
    step(1, 1, 1, vec_of(3), 1);
    check_model("flush_full");
    chk("flush_full state", 64'(occupancy), 64'd0);

    // Counter saturation on the 4-bit instance.
    step(0, 0, 0, vec_of(0), 0);
    step(1, 0, 1, vec_of(5), 0);
    for (int c = 0; c < 20; c++) step(1, 0, 0, vec_of(0), 0);
    chk("sat stall4", 64'(stall_cnt_s), 64'd15);
    chk("sat stall16", 64'(stall_cnt), 64'd20);
    step(1, 0, 0, vec_of(0), 0);
    chk("sat hold stall4", 64'(stall_cnt_s), 64'd15);
    check_model("sat");

    // Randomized traffic against the queue model.
    for (int c = 0; c < 600; c++) begin
      tvec_t rv;
      for (int i = 0; i < 4; i++) rv[i] = $urandom;
      step(($urandom_range(0, 60) != 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 9) < 7), rv, ($urandom_range(0, 9) < 5));
      check_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
